// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the control-flag bundle that travels
// alongside each pixel through the video pipeline.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int PIPE_DELAY_DEF = 2;

  localparam int H_TOTAL_DEF    = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF    = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START   = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END     = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START   = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END     = V_SYNC_START + V_SYNC_DEF;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_ctl_t;

  // Blanked, both syncs de-asserted (syncs are active low).
  localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register that delays the raster control flags so they
// meet the colour coming back from the object/mux pipeline.
module vga_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_output_stage.sv
// Raster counters, sync/blank decode and the registered DAC outputs. Flags are
// delayed by PIPE_DELAY so they line up with the colour from the object mux.
module vga_output_stage
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVGA_SYNC_N
);

  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hCnt;
  logic [10:0] vCnt;
  vga_ctl_t    ctl_p0;
  vga_ctl_t    ctl_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hCnt == H_LAST) begin
      hCnt <= '0;
      vCnt <= (vCnt == V_LAST) ? 11'd0 : vCnt + 11'd1;
    end else begin
      hCnt <= hCnt + 11'd1;
    end
  end

  assign pixelX       = hCnt;
  assign pixelY       = vCnt;
  assign startOfFrame = (hCnt == 11'd0) && (vCnt == 11'd0);
  assign oVGA_SYNC_N  = 1'b0;

  // Stage 0: flags decoded straight from the counters
  always_comb begin
    ctl_p0        = CTL_IDLE;
    ctl_p0.active = (hCnt < H_ACT) && (vCnt < V_ACT);
    ctl_p0.hs     = !((hCnt >= HS_START) && (hCnt < HS_END));
    ctl_p0.vs     = !((vCnt >= VS_START) && (vCnt < VS_END));
  end

  // Stages 1..PIPE_DELAY: flags wait for the object + mux pipeline
  vga_delay_line #(
    .WIDTH     ($bits(vga_ctl_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (CTL_IDLE)
  ) u_delay (
    .clk    (clk),
    .resetN (resetN),
    .din    (ctl_p0),
    .dout   (ctl_d)
  );

  // Output register: colour and flags sampled on the same edge describe the same pixel
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      oVGA_R       <= 8'h00;
      oVGA_G       <= 8'h00;
      oVGA_B       <= 8'h00;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      oVGA_R       <= ctl_d.active ? redIn   : 8'h00;
      oVGA_G       <= ctl_d.active ? greenIn : 8'h00;
      oVGA_B       <= ctl_d.active ? blueIn  : 8'h00;
      oVGA_HS      <= ctl_d.hs;
      oVGA_VS      <= ctl_d.vs;
      oVGA_BLANK_N <= ctl_d.active;
    end
  end

endmodule
